counter_updown_mod: RTL

Parametrised up/down modulo counter, the general-purpose successor to the basic enable counter. It adds:
- a programmable terminal value;
- direction control;
- wrap or saturate mode;
- a clamped synchronous load;
- a built-in enable prescaler;
- a one-cycle wrap pulse for chaining.

It is intended for game timers (drop-rate ticks, row/column indices, score digits) where several counters cascade off one clock.

---
 rtl/counter_updown_mod.sv | 90 +++++++++
 1 files changed

// File: rtl/counter_updown_mod.sv
// Up/down modulo counter: programmable terminal value, wrap or saturate, clamped load,
// enable prescaler and a registered wrap pulse that can enable a downstream counter.
module counter_updown_mod #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 2**W-1,
  parameter int unsigned DIV = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         enable,
  input  logic         up,
  input  logic         sat,
  output logic [W-1:0] q,
  output logic         at_max,
  output logic         at_zero,
  output logic         wrap
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  MAX_V    = W'(MAX);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          wrap_q, wrap_d;

  // Next-state selection: clear, then load, then prescaled step, else hold.
  always_comb begin
    cnt_d  = cnt_q;
    pre_d  = pre_q;
    wrap_d = 1'b0;
    if (clear) begin
      cnt_d = {W{1'b0}};
      pre_d = {PW{1'b0}};
    end else if (load) begin
      cnt_d = (d > MAX_V) ? MAX_V : d;
      pre_d = {PW{1'b0}};
    end else if (enable) begin
      if (pre_q == PRE_LAST) begin
        pre_d = {PW{1'b0}};
        // Ends of range are handled explicitly so no 2**W overflow is ever relied on.
        if (up) begin
          if (cnt_q != MAX_V) begin
            cnt_d = cnt_q + W'(1);
          end else if (sat) begin
            cnt_d = MAX_V;
          end else begin
            cnt_d  = {W{1'b0}};
            wrap_d = 1'b1;
          end
        end else begin
          if (cnt_q != {W{1'b0}}) begin
            cnt_d = cnt_q - W'(1);
          end else if (sat) begin
            cnt_d = {W{1'b0}};
          end else begin
            cnt_d  = MAX_V;
            wrap_d = 1'b1;
          end
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end else begin
      pre_d = pre_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= {W{1'b0}};
      pre_q  <= {PW{1'b0}};
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pre_q  <= pre_d;
      wrap_q <= wrap_d;
    end
  end

  assign q       = cnt_q;
  assign wrap    = wrap_q;
  assign at_max  = (cnt_q == MAX_V);
  assign at_zero = (cnt_q == {W{1'b0}});

endmodule
